// File: rtl/iobuf_ctrl.sv
// iobuf_ctrl: direction/drive sequencer for one IO channel.
// Steps the level-shifter DIR, the open-drain buffer input and the FPGA
// tristate enable in break-before-make order, with SETTLE_CYCLES-long gaps.
// This keeps the FPGA from driving into a buffer set to input, and keeps the
// two buffers from fighting on the header. Also synchronizes the pin input.
module iobuf_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       mode_valid,
    output logic       mode_ready,
    output logic [1:0] mode_cur,
    input  logic       dout,
    output logic       din,
    output logic       bufdir,
    output logic       bufod,
    output logic       bufdat_tristate_oe,
    output logic       bufdat_tristate_dout,
    input  logic       bufdat_tristate_din
);
    localparam int            CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] M_IN = 2'b00;
    localparam logic [1:0] M_PP = 2'b01;
    localparam logic [1:0] M_OD = 2'b10;

    typedef enum logic [2:0] {
        ST_IN, ST_OD, ST_PP, ST_OD_OFF, ST_DIR_ON, ST_OE_OFF, ST_DIR_OFF
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_tgt, w_tgt_nxt;
    logic [1:0]    r_cur, w_cur_nxt;
    logic          r_dir, w_dir_nxt;
    logic          r_od, w_od_nxt;
    logic          r_oe, w_oe_nxt;
    logic          r_tdout, w_tdout_nxt;
    logic [1:0]    r_sync;

    logic          w_stable;
    logic          w_acc;
    logic [1:0]    w_req;
    logic          w_expired;

    assign w_stable  = (r_state == ST_IN) || (r_state == ST_OD) || (r_state == ST_PP);
    assign w_req     = (mode_req == 2'b11) ? M_IN : mode_req;
    assign w_acc     = mode_valid && mode_ready;
    assign w_expired = (r_cnt == '0);

    assign mode_ready           = w_stable && !reset;
    assign mode_cur             = r_cur;
    assign bufdir               = r_dir;
    assign bufod                = r_od;
    assign bufdat_tristate_oe   = r_oe;
    assign bufdat_tristate_dout = r_tdout;
    assign din                  = r_sync[1];

    // State, settle counter and all buffer controls; reset forces IN outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IN;
            r_cnt   <= '0;
            r_tgt   <= M_IN;
            r_cur   <= M_IN;
            r_dir   <= 1'b0;
            r_od    <= 1'b1;
            r_oe    <= 1'b0;
            r_tdout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tgt   <= w_tgt_nxt;
            r_cur   <= w_cur_nxt;
            r_dir   <= w_dir_nxt;
            r_od    <= w_od_nxt;
            r_oe    <= w_oe_nxt;
            r_tdout <= w_tdout_nxt;
        end
    end

    // Next state and next control values; each wait state drops one control.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt;
        w_cur_nxt   = r_cur;
        w_dir_nxt   = r_dir;
        w_od_nxt    = r_od;
        w_oe_nxt    = r_oe;
        w_tdout_nxt = r_tdout;
        case (r_state)
            ST_IN: begin
                if (w_acc && w_req == M_PP) begin
                    w_dir_nxt   = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_DIR_ON;
                end else if (w_acc && w_req == M_OD) begin
                    w_od_nxt    = dout;
                    w_cur_nxt   = M_OD;
                    w_state_nxt = ST_OD;
                end
            end
            ST_OD: begin
                w_od_nxt = dout;
                if (w_acc && w_req == M_PP) begin
                    // release the pull-down before turning the level shifter around
                    w_od_nxt    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_OD_OFF;
                end else if (w_acc && w_req == M_IN) begin
                    w_od_nxt    = 1'b1;
                    w_cur_nxt   = M_IN;
                    w_state_nxt = ST_IN;
                end
            end
            ST_PP: begin
                w_tdout_nxt = dout;
                if (w_acc && w_req != M_PP) begin
                    w_oe_nxt    = 1'b0;
                    w_tdout_nxt = 1'b0;
                    w_tgt_nxt   = w_req;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_OE_OFF;
                end
            end
            ST_OD_OFF: begin
                if (w_expired) begin
                    w_dir_nxt   = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_DIR_ON;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_DIR_ON: begin
                if (w_expired) begin
                    w_oe_nxt    = 1'b1;
                    w_tdout_nxt = dout;
                    w_cur_nxt   = M_PP;
                    w_state_nxt = ST_PP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_OE_OFF: begin
                if (w_expired) begin
                    w_dir_nxt   = 1'b0;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_DIR_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_DIR_OFF: begin
                if (w_expired) begin
                    w_cur_nxt   = r_tgt;
                    w_od_nxt    = (r_tgt == M_OD) ? dout : 1'b1;
                    w_state_nxt = (r_tgt == M_OD) ? ST_OD : ST_IN;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = ST_IN;
        endcase
    end

    // Two-flop synchronizer for the raw pin input.
    always_ff @(posedge clock) begin
        if (reset) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], bufdat_tristate_din};
    end
endmodule

// File: tb/tb_iobuf_ctrl.sv
// Bench for iobuf_ctrl: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a timeline model.
module tb_iobuf_ctrl;
    localparam int S = 4;
    localparam logic [1:0] M_IN = 2'b00;
    localparam logic [1:0] M_PP = 2'b01;
    localparam logic [1:0] M_OD = 2'b10;

    logic       clock;
    logic       reset;
    logic [1:0] mode_req;
    logic       mode_valid;
    logic       mode_ready;
    logic [1:0] mode_cur;
    logic       dout;
    logic       din;
    logic       bufdir;
    logic       bufod;
    logic       bufdat_tristate_oe;
    logic       bufdat_tristate_dout;
    logic       bufdat_tristate_din;

    iobuf_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clock(clock), .reset(reset),
        .mode_req(mode_req), .mode_valid(mode_valid),
        .mode_ready(mode_ready), .mode_cur(mode_cur),
        .dout(dout), .din(din),
        .bufdir(bufdir), .bufod(bufod),
        .bufdat_tristate_oe(bufdat_tristate_oe),
        .bufdat_tristate_dout(bufdat_tristate_dout),
        .bufdat_tristate_din(bufdat_tristate_din)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {ready, mode_cur, dir, od, oe, tdout}
    logic [6:0] obs;
    assign obs = {mode_ready, mode_cur, bufdir, bufod, bufdat_tristate_oe, bufdat_tristate_dout};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model: transition timeline ----------------
    // A transition from m_from to m_to accepted at edge m_k finishes after
    // dur() edges; outputs in between follow the break-before-make timeline.
    int         e_cyc = 0;
    int         m_k = 0;
    logic [1:0] m_from = M_IN, m_to = M_IN;
    logic       m_dout = 1'b0, m_d1 = 1'b0, m_d2 = 1'b0, m_on = 1'b0;
    int         dir_run = 0;

    function automatic int dur(input logic [1:0] f, input logic [1:0] t);
        if (f == t)    return 0;
        if (t == M_PP) return (f == M_OD) ? 2 * S : S;
        if (f == M_PP) return 2 * S;
        return 0;
    endfunction

    function automatic logic [6:0] exp_vec(input int d, input logic rst_now);
        logic rdy, dr, od, oe, td;
        logic [1:0] cur;
        if (d >= dur(m_from, m_to)) begin
            rdy = 1'b1; cur = m_to;
            dr  = (m_to == M_PP); oe = dr;
            td  = dr ? m_dout : 1'b0;
            od  = (m_to == M_OD) ? m_dout : 1'b1;
        end else begin
            rdy = 1'b0; od = 1'b1; oe = 1'b0; td = 1'b0;
            if (m_to == M_PP && m_from == M_IN) begin cur = M_IN; dr = 1'b1; end
            else if (m_to == M_PP)              begin cur = M_OD; dr = (d >= S); end
            else                                begin cur = M_PP; dr = (d < S); end
        end
        return {rdy & ~rst_now, cur, dr, od, oe, td};
    endfunction

    // Advance the model on each edge, then compare a little after the edge.
    always @(posedge clock) begin
        if (reset) begin
            m_from = M_IN; m_to = M_IN; m_k = e_cyc + 1;
            m_d1 = 1'b0; m_d2 = 1'b0; m_on = 1'b1;
        end else if (m_on) begin
            if (mode_valid && (e_cyc - m_k >= dur(m_from, m_to))) begin
                m_from = m_to;
                m_to   = (mode_req == 2'b11) ? M_IN : mode_req;
                m_k    = e_cyc + 1;
            end
            m_d2 = m_d1;
            m_d1 = bufdat_tristate_din;
        end
        m_dout = dout;
        e_cyc++;
        #3;
        if (m_on) begin
            chk("model_out", obs, exp_vec(e_cyc - m_k, reset));
            chk("model_din", din, m_d2);
            chk("invariants",
                {(!bufdir && bufdat_tristate_oe), (bufdir && !bufod),
                 (bufdat_tristate_oe && dir_run < S)}, 3'b000);
            dir_run = bufdir ? dir_run + 1 : 0;
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] req;
        logic       dt;
        logic       raw;
        logic [6:0] exp;
    } vec_t;

    localparam int NV = 22;
    vec_t tv[NV];
    logic [6:0] ex;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic din_seq(input string nm);
        bufdat_tristate_din = 1'b0; step(); step();
        bufdat_tristate_din = 1'b1; step();
        chk({nm, "_din_e1"}, din, 1'b0);
        step();
        chk({nm, "_din_e2"}, din, 1'b1);
    endtask

    initial begin
        // rows assume S=4; expected = outputs seen after that row's edge
        tv[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 7'b0_00_0100};
        tv[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 7'b0_00_0100};
        tv[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 7'b0_00_0100};
        tv[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'b1_00_0100};
        tv[4]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 7'b0_00_1100}; // IN->PP accepted
        tv[5]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'b0_00_1100};
        tv[6]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'b0_00_1100};
        tv[7]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'b0_00_1100};
        tv[8]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'b1_01_1111}; // PP at k+S
        tv[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 7'b0_01_1100}; // PP->OD accepted
        tv[10] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 7'b0_01_1100}; // ignored pulses
        tv[11] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 7'b0_01_1100};
        tv[12] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 7'b0_01_1100};
        tv[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'b0_01_0100}; // dir off at k+S
        tv[14] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 7'b0_01_0100};
        tv[15] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 7'b0_01_0100};
        tv[16] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 7'b0_01_0100};
        tv[17] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'b1_10_0000}; // OD at k+2S, od=0
        tv[18] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'b1_10_0100}; // od follows dout
        tv[19] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 7'b1_00_0100}; // OD->IN direct
        tv[20] = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 7'b1_10_0000}; // IN->OD direct
        tv[21] = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 7'b1_10_0000}; // same mode

        reset = 1'b1; mode_valid = 1'b0; mode_req = 2'b00;
        dout = 1'b0; bufdat_tristate_din = 1'b0;

        for (int i = 0; i < NV; i++) begin
            reset = tv[i].rst; mode_valid = tv[i].vld; mode_req = tv[i].req;
            dout = tv[i].dt; bufdat_tristate_din = tv[i].raw;
            step();
            chk($sformatf("vec%0d", i), obs, tv[i].exp);
        end

        // OD (dout=0) -> PP: od released first, then dir, then oe
        mode_valid = 1'b1; mode_req = M_PP; dout = 1'b0;
        step();
        mode_valid = 1'b0; dout = 1'b1;
        chk("odpp_k1", obs, 7'b0_10_0100);
        for (int d = 1; d <= 2 * S; d++) begin
            step();
            ex = (d >= 2 * S) ? 7'b1_01_1111 : ((d >= S) ? 7'b0_10_1100 : 7'b0_10_0100);
            chk($sformatf("odpp_d%0d", d), obs, ex);
        end

        // reset two cycles into OE_OFF, then IN->OD after release
        bufdat_tristate_din = 1'b1;
        mode_valid = 1'b1; mode_req = M_IN;
        step();
        mode_valid = 1'b0;
        chk("ppin_k1", obs, 7'b0_01_1100);
        step(); step();
        reset = 1'b1;
        step();
        chk("rst_mid", obs, 7'b0_00_0100);
        chk("rst_din", din, 1'b0);
        reset = 1'b0;
        step();
        chk("rst_rel", obs, 7'b1_00_0100);
        mode_valid = 1'b1; mode_req = M_OD; dout = 1'b0;
        step();
        mode_valid = 1'b0;
        chk("in_od", obs, 7'b1_10_0000);
        dout = 1'b1;
        step();
        chk("od_data", obs, 7'b1_10_0100);

        // synchronizer latency per mode, reserved request from IN
        din_seq("od");
        mode_valid = 1'b1; mode_req = M_IN;
        step();
        chk("od_in", obs, 7'b1_00_0100);
        mode_req = 2'b11;
        step();
        mode_valid = 1'b0;
        chk("req11", obs, 7'b1_00_0100);
        din_seq("in");
        mode_valid = 1'b1; mode_req = M_PP; dout = 1'b1;
        step();
        mode_valid = 1'b0;
        repeat (S) step();
        chk("in_pp", obs, 7'b1_01_1111);
        din_seq("pp");

        // random traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            reset               = ($urandom_range(0, 99) == 0);
            mode_valid          = ($urandom_range(0, 3) == 0);
            mode_req            = 2'($urandom_range(0, 3));
            dout                = 1'($urandom_range(0, 1));
            bufdat_tristate_din = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/iobuf_ctrl.md
# iobuf_ctrl

Per-pin direction/drive sequencer for one Bus Pirate IO channel: 74LVC1T45 bidirectional buffer (DIR), 74LVC1G07 open-drain buffer (OD) and the FPGA tristate data pin. It accepts mode requests (input/HiZ, push-pull, open-drain) from the protocol engines. It steps the three controls in break-before-make order with programmable settle gaps, so the FPGA pin never drives into a buffer set to input and the two buffers never drive the header against each other. It also synchronizes the pin input into the clock domain.

## Interface
- SETTLE_CYCLES, 4, length of each settle gap in clocks; legal range 1..255; counter width $clog2(SETTLE_CYCLES+1).
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode_req  input  2  requested mode: 00 input/HiZ, 01 push-pull, 10 open-drain, 11 reserved (treated as 00).
- mode_valid  input  1  request strobe; accepted when mode_valid && mode_ready.
- mode_ready  output  1  high in stable states (IN, OD, PP) and not in reset.
- mode_cur  output  2  mode currently applied (00/01/10); changes only on entry to a stable state.
- dout  input  1  data to drive in PP/OD modes.
- din  output  1  pin input after 2-flop synchronizer.
- bufdir  output  1  74LVC1T45 DIR; 1 = FPGA drives header.
- bufod  output  1  74LVC1G07 input; 0 pulls header to GND, 1 = HiZ.
- bufdat_tristate_oe  output  1  FPGA data pin output enable.
- bufdat_tristate_dout  output  1  FPGA data pin output value.
- bufdat_tristate_din  input  1  FPGA data pin raw input.

## Operation
- All buffer-control outputs are registered. Reset values: bufdir=0, bufod=1, bufdat_tristate_oe=0, bufdat_tristate_dout=0, din=0, mode_cur=00, mode_ready=0. The state is IN.
- States: IN, OD, PP (stable). OD_OFF, DIR_ON, OE_OFF and DIR_OFF are wait states; each lasts exactly SETTLE_CYCLES cycles using a down-counter.
- Stable-state outputs:
  - IN: dir=0, od=1, oe=0, tdout=0.
  - OD: dir=0, od=dout (registered), oe=0, tdout=0.
  - PP: dir=1, od=1, oe=1, tdout=dout (registered).
- Transitions on accept:
  - IN->PP: dir=1, enter DIR_ON; on expiry oe=1 and enter PP.
  - OD->PP: od=1, enter OD_OFF; on expiry dir=1 and enter DIR_ON; then as above.
  - PP->IN or PP->OD: oe=0, enter OE_OFF; on expiry dir=0 and enter DIR_OFF; on expiry enter target; od follows dout from that edge if the target is OD.
  - IN<->OD: direct. od updates at the next edge and mode_cur updates at the same edge. No wait state.
  - Request equal to mode_cur, or 11 while in IN: accepted, no output change.
- mode_valid while mode_ready=0 is ignored and not queued.
- Invariants, checked every cycle:
  - never (bufdir=0 && bufdat_tristate_oe=1);
  - never (bufdir=1 && bufod=0);
  - oe=1 implies dir=1 for at least SETTLE_CYCLES prior cycles.
- Reset mid-transition: at the reset edge all outputs take reset values. This sets oe=0 and dir=0 together, which violates no invariant. Pending state and counter are discarded.
- din = bufdat_tristate_din through two flops in all modes.

## Timing
- Request accepted at edge k.
- IN->PP: dir=1 at k+1; oe=1, mode_cur=01 and ready=1 at k+1+S.
- OD->PP: od=1 at k+1; dir=1 at k+1+S; oe=1 and ready=1 at k+1+2S.
- PP->IN/OD: oe=0 at k+1; dir=0 at k+1+S; stable target and ready=1 at k+1+2S.
- IN<->OD: new od and mode_cur at k+1; ready stays high.
- Data latency: dout to tdout (PP) or to od (OD) is 1 cycle. bufdat_tristate_din to din is 2 cycles.
- mode_ready is combinational from state and reset; it drops in the cycle after accept for any wait-state transition.

## Test plan
- Reset held 3 cycles then released -> outputs dir=0, od=1, oe=0, tdout=0, mode_cur=00 during reset; mode_ready=1 on the first cycle after release.
- S=4, IN->PP request, dout=1 -> dir=1 at k+1, oe=1 and tdout=1 at k+5, mode_cur=01; no cycle with dir=0&&oe=1.
- S=4, PP->OD with dout=0 -> oe=0 at k+1, dir=0 at k+5, od=0 at k+9, mode_cur=10; mode_valid pulses during the wait are ignored.
- S=3, OD(dout=0)->PP -> od=1 at k+1, dir=1 at k+4, oe=1 at k+7; no cycle has dir=1&&od=0.
- Reset asserted in PP, 2 cycles into OE_OFF -> next edge all reset values; after release, an IN->OD request applies od=dout at k+1.
- Toggle bufdat_tristate_din 0->1 -> din=1 exactly 2 edges later in every mode; the 11 request from IN produces no output change and ready stays 1.
